// File: rtl/batt_sched_pkg.sv
// Shared types and default thresholds for the battery conversion scheduler.
// cmd_cfg imports the threshold defaults so both blocks agree on the levels.
package batt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UPDATE = 2'd3
  } state_t;

  typedef logic [11:0] batt_lvl_t;

  localparam int unsigned DEF_PERIOD   = 2500000;
  localparam int unsigned DEF_TIMEOUT  = 4096;
  localparam int unsigned DEF_AVG_LOG2 = 2;
  localparam batt_lvl_t   DEF_LOW_THR  = 12'd2560;
  localparam batt_lvl_t   DEF_CRIT_THR = 12'd2304;
  localparam batt_lvl_t   DEF_HYST     = 12'd64;

endpackage

// File: rtl/batt_filt.sv
// Exponential moving average of the battery level plus low/critical flags.
// Flags are judged on the freshly computed average, with hysteresis on release.
module batt_filt
  import batt_sched_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2,
  parameter batt_lvl_t   LOW_THR  = DEF_LOW_THR,
  parameter batt_lvl_t   CRIT_THR = DEF_CRIT_THR,
  parameter batt_lvl_t   HYST     = DEF_HYST
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_load,
  input  logic      i_seed,
  input  batt_lvl_t i_sample,
  output batt_lvl_t o_avg,
  output logic      o_low,
  output logic      o_crit
);

  localparam logic [12:0] LOW_CLR  = 13'(LOW_THR) + 13'(HYST);
  localparam logic [12:0] CRIT_CLR = 13'(CRIT_THR) + 13'(HYST);

  batt_lvl_t          r_avg;
  logic               r_low;
  logic               r_crit;
  logic signed [12:0] w_diff;
  logic signed [12:0] w_step;
  logic signed [12:0] w_sum;
  batt_lvl_t          w_new;

  // The sum always lands in 0..4095, so dropping the sign bit is lossless.
  always_comb begin
    w_diff = $signed({1'b0, i_sample}) - $signed({1'b0, r_avg});
    w_step = w_diff >>> AVG_LOG2;
    w_sum  = $signed({1'b0, r_avg}) + w_step;
    w_new  = i_seed ? i_sample : batt_lvl_t'(w_sum);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_avg  <= '0;
      r_low  <= 1'b0;
      r_crit <= 1'b0;
    end else if (i_load) begin
      r_avg <= w_new;
      if (w_new < LOW_THR)
        r_low <= 1'b1;
      else if ({1'b0, w_new} >= LOW_CLR)
        r_low <= 1'b0;
      if (w_new < CRIT_THR)
        r_crit <= 1'b1;
      else if ({1'b0, w_new} >= CRIT_CLR)
        r_crit <= 1'b0;
    end
  end

  assign o_avg  = r_avg;
  assign o_low  = r_low;
  assign o_crit = r_crit;

endmodule

// File: rtl/batt_sched.sv
// Battery A2D conversion scheduler: periodic timer and cmd_cfg requests share one
// conversion engine. States: IDLE=wait for pend | START=strt_cnv | WAIT=await cnv_cmplt | UPDATE=filter.
module batt_sched
  import batt_sched_pkg::*;
#(
  parameter int unsigned PERIOD   = DEF_PERIOD,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2,
  parameter batt_lvl_t   LOW_THR  = DEF_LOW_THR,
  parameter batt_lvl_t   CRIT_THR = DEF_CRIT_THR,
  parameter batt_lvl_t   HYST     = DEF_HYST
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mon_en,
  input  logic        i_cmd_req,
  output logic        o_cmd_ack,
  output logic        o_strt_cnv,
  input  logic        i_cnv_cmplt,
  input  logic [11:0] i_res,
  output logic [11:0] o_batt_raw,
  output logic [11:0] o_batt_avg,
  output logic        o_batt_low,
  output logic        o_batt_crit,
  output logic        o_a2d_fault,
  output logic        o_busy
);

  localparam int TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [TMR_W-1:0] r_tmr;
  logic [TO_W-1:0]  r_to;
  logic             r_tmr_pend;
  logic             r_cmd_pend;
  logic             r_owner;
  logic             r_seeded;
  logic             r_fault;
  logic             r_ack;
  batt_lvl_t        r_raw;
  logic             w_tick;
  logic             w_take;
  logic             w_timeout;
  logic             w_load;

  assign w_tick = i_mon_en && (r_tmr == TMR_LAST);

  always_comb begin
    w_next    = r_state;
    w_take    = 1'b0;
    w_timeout = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_cmd_pend || r_tmr_pend) begin
          w_next = START;
          w_take = 1'b1;
        end
      end
      START: w_next = WAIT;
      WAIT: begin
        if (i_cnv_cmplt) begin
          w_next = UPDATE;
        end else if (r_to == TO_LAST) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      UPDATE: begin
        w_next = IDLE;
        w_load = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // A request arriving in the same cycle a conversion is taken re-arms the pend
  // flag, so it is served by a conversion that starts after it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_tmr      <= '0;
      r_to       <= '0;
      r_tmr_pend <= 1'b0;
      r_cmd_pend <= 1'b0;
      r_owner    <= 1'b0;
      r_seeded   <= 1'b0;
      r_fault    <= 1'b0;
      r_ack      <= 1'b0;
      r_raw      <= '0;
    end else begin
      r_state    <= w_next;
      r_tmr      <= (!i_mon_en || w_tick) ? '0 : r_tmr + 1'b1;
      r_tmr_pend <= i_mon_en && (w_tick || (r_tmr_pend && !w_take));
      r_cmd_pend <= i_cmd_req || (r_cmd_pend && !w_take);
      if (w_take)
        r_owner <= r_cmd_pend;
      r_to <= (r_state == WAIT) ? r_to + 1'b1 : '0;
      if ((r_state == WAIT) && i_cnv_cmplt)
        r_raw <= i_res;
      if (w_timeout)
        r_fault <= 1'b1;
      r_ack <= r_owner && (w_load || w_timeout);
      if (w_load)
        r_seeded <= 1'b1;
    end
  end

  batt_filt #(
    .AVG_LOG2 (AVG_LOG2),
    .LOW_THR  (LOW_THR),
    .CRIT_THR (CRIT_THR),
    .HYST     (HYST)
  ) u_filt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_load),
    .i_seed   (!r_seeded),
    .i_sample (r_raw),
    .o_avg    (o_batt_avg),
    .o_low    (o_batt_low),
    .o_crit   (o_batt_crit)
  );

  assign o_strt_cnv  = (r_state == START);
  assign o_busy      = (r_state != IDLE);
  assign o_cmd_ack   = r_ack;
  assign o_batt_raw  = r_raw;
  assign o_a2d_fault = r_fault;

endmodule

// File: tb/tb_batt_sched.sv
// Self-checking bench for batt_sched: A2D responder model, ack scoreboard,
// table-driven filter vectors and hand-written multi-cycle sequences.
module tb_batt_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mon_en = 1'b0;
  logic        cmd_req = 1'b0;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = '0;
  logic        cmd_ack, strt_cnv, batt_low, batt_crit, a2d_fault, busy;
  logic [11:0] batt_raw, batt_avg;

  batt_sched #(.PERIOD(100), .TIMEOUT(50)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mon_en    (mon_en),
    .i_cmd_req   (cmd_req),
    .o_cmd_ack   (cmd_ack),
    .o_strt_cnv  (strt_cnv),
    .i_cnv_cmplt (cnv_cmplt),
    .i_res       (res),
    .o_batt_raw  (batt_raw),
    .o_batt_avg  (batt_avg),
    .o_batt_low  (batt_low),
    .o_batt_crit (batt_crit),
    .o_a2d_fault (a2d_fault),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] raw;
    logic [11:0] avg;
    logic        low;
    logic        crit;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [11:0] sample;
    logic [11:0] avg;
    logic        low;
    logic        crit;
  } vec_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          n_strt = 0;
  int          n_ack = 0;
  int          last_strt = 0;
  int          last_ack = 0;
  logic        a2d_respond = 1'b1;
  logic [11:0] a2d_val = '0;
  logic [11:0] a2d_cap = '0;
  int          a2d_delay = 20;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: counts pulses and pops the scoreboard on every cmd_ack.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (strt_cnv) begin
        n_strt++;
        last_strt = cyc;
      end
      if (cmd_ack) begin
        n_ack++;
        last_ack = cyc;
        check("sb_has_entry", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("ack_raw", batt_raw, e.raw);
          check("ack_avg", batt_avg, e.avg);
          check("ack_low", batt_low, e.low);
          check("ack_crit", batt_crit, e.crit);
          check("ack_fault", a2d_fault, e.fault);
        end
      end
    end
  end

  // A2D model: answers a start pulse after a2d_delay clocks when enabled.
  initial forever begin
    @(negedge clk);
    if (strt_cnv && a2d_respond) begin
      a2d_cap = a2d_val;
      repeat (a2d_delay - 1) @(posedge clk);
      #1 res = a2d_cap;
      cnv_cmplt = 1'b1;
      @(posedge clk);
      #1 cnv_cmplt = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic pulse_req(output int t);
    @(posedge clk);
    #1 cmd_req = 1'b1;
    t = cyc;
    @(posedge clk);
    #1 cmd_req = 1'b0;
  endtask

  task automatic wait_strts(input int target, input int budget, input string name);
    int k = 0;
    while (n_strt < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(name, n_strt, target);
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int k = 0;
    while (n_ack < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(name, n_ack, target);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    @(negedge clk);
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, busy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b0;
    cmd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    vec_t vecs[12];
    int   t0, t1, s0, a0, ts, k;

    vecs = '{
      '{12'd2600, 12'd2600, 1'b0, 1'b0},
      '{12'd2500, 12'd2575, 1'b0, 1'b0},
      '{12'd2500, 12'd2556, 1'b1, 1'b0},
      '{12'd2700, 12'd2592, 1'b1, 1'b0},
      '{12'd2700, 12'd2619, 1'b1, 1'b0},
      '{12'd2700, 12'd2639, 1'b0, 1'b0},
      '{12'd2000, 12'd2479, 1'b1, 1'b0},
      '{12'd2000, 12'd2359, 1'b1, 1'b0},
      '{12'd2000, 12'd2269, 1'b1, 1'b1},
      '{12'd2400, 12'd2301, 1'b1, 1'b1},
      '{12'd2400, 12'd2325, 1'b1, 1'b1},
      '{12'd3000, 12'd2493, 1'b1, 1'b0}
    };

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_strt", strt_cnv, 0);
    check("rst_ack", cmd_ack, 0);
    check("rst_raw", batt_raw, 0);
    check("rst_avg", batt_avg, 0);
    check("rst_low", batt_low, 0);
    check("rst_crit", batt_crit, 0);
    check("rst_fault", a2d_fault, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Periodic conversions
    a2d_val = 12'd3000;
    s0 = n_strt;
    a0 = n_ack;
    @(posedge clk);
    #1 mon_en = 1'b1;
    wait_strts(s0 + 1, 250, "per_strt1");
    t0 = last_strt;
    wait_idle(100, "per_idle1");
    check("per_raw", batt_raw, 3000);
    check("per_avg", batt_avg, 3000);
    check("per_low", batt_low, 0);
    check("per_crit", batt_crit, 0);
    wait_strts(s0 + 2, 250, "per_strt2");
    t1 = last_strt;
    check("per_interval1", t1 - t0, 100);
    wait_strts(s0 + 3, 250, "per_strt3");
    check("per_interval2", last_strt - t1, 100);
    check("per_no_ack", n_ack, a0);
    @(posedge clk);
    #1 mon_en = 1'b0;
    wait_idle(100, "per_idle_end");

    // On-demand request seeds the filter
    do_reset();
    a2d_val = 12'd2000;
    sb.push_back('{12'd2000, 12'd2000, 1'b1, 1'b1, 1'b0});
    s0 = n_strt;
    a0 = n_ack;
    pulse_req(t0);
    wait_strts(s0 + 1, 20, "req_strt");
    check("req_to_strt", last_strt - t0, 2);
    wait_acks(a0 + 1, 100, "req_ack");
    repeat (10) @(posedge clk);
    check("req_single_ack", n_ack, a0 + 1);

    // Filter and hysteresis vectors
    do_reset();
    for (int i = 0; i < 12; i++) begin
      a2d_val = vecs[i].sample;
      sb.push_back('{vecs[i].sample, vecs[i].avg, vecs[i].low, vecs[i].crit, 1'b0});
      a0 = n_ack;
      pulse_req(t0);
      wait_acks(a0 + 1, 100, "vec_ack");
    end

    // cmd_req coincident with timer tick
    do_reset();
    a2d_val = 12'd3000;
    sb.push_back('{12'd3000, 12'd3000, 1'b0, 1'b0, 1'b0});
    s0 = n_strt;
    a0 = n_ack;
    @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (99) @(posedge clk);
    #1 cmd_req = 1'b1;
    @(posedge clk);
    #1 cmd_req = 1'b0;
    wait_acks(a0 + 1, 100, "coinc_ack");
    #1 mon_en = 1'b0;
    repeat (30) @(posedge clk);
    check("coinc_one_strt", n_strt, s0 + 1);
    check("coinc_one_ack", n_ack, a0 + 1);

    // cmd_req arriving during WAIT gets a fresh conversion
    do_reset();
    a2d_val = 12'd3000;
    sb.push_back('{12'd3000, 12'd3000, 1'b0, 1'b0, 1'b0});
    s0 = n_strt;
    a0 = n_ack;
    pulse_req(t0);
    wait_strts(s0 + 1, 20, "wreq_strt1");
    repeat (5) @(posedge clk);
    a2d_val = 12'd2800;
    sb.push_back('{12'd2800, 12'd2950, 1'b0, 1'b0, 1'b0});
    pulse_req(t0);
    wait_acks(a0 + 1, 100, "wreq_ack1");
    t1 = last_ack;
    wait_strts(s0 + 2, 20, "wreq_strt2");
    check("wreq_strt_after_ack", last_strt > t1, 1);
    wait_acks(a0 + 2, 100, "wreq_ack2");
    repeat (10) @(posedge clk);
    check("wreq_two_strt", n_strt, s0 + 2);

    // Conversion timeout
    do_reset();
    a2d_val = 12'd3000;
    sb.push_back('{12'd3000, 12'd3000, 1'b0, 1'b0, 1'b0});
    a0 = n_ack;
    pulse_req(t0);
    wait_acks(a0 + 1, 100, "to_seed_ack");
    a2d_respond = 1'b0;
    sb.push_back('{12'd3000, 12'd3000, 1'b0, 1'b0, 1'b1});
    s0 = n_strt;
    pulse_req(t0);
    wait_strts(s0 + 1, 20, "to_strt");
    ts = last_strt;
    k = 0;
    @(negedge clk);
    while (!a2d_fault && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("to_fault", a2d_fault, 1);
    check("to_delay_window", ((cyc - ts) >= 50) && ((cyc - ts) <= 51), 1);
    wait_acks(a0 + 2, 20, "to_ack");
    a2d_respond = 1'b1;
    a2d_val = 12'd3000;
    s0 = n_strt;
    a0 = n_ack;
    @(posedge clk);
    #1 mon_en = 1'b1;
    wait_strts(s0 + 1, 250, "to_restart");
    wait_idle(100, "to_restart_idle");
    #1 mon_en = 1'b0;
    check("to_fault_sticky", a2d_fault, 1);
    check("to_restart_avg", batt_avg, 3000);
    check("to_restart_no_ack", n_ack, a0);

    // Reset mid-conversion, then a late cnv_cmplt
    do_reset();
    a2d_val = 12'd1234;
    s0 = n_strt;
    a0 = n_ack;
    pulse_req(t0);
    wait_strts(s0 + 1, 20, "mrst_strt");
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("mrst_raw", batt_raw, 0);
    check("mrst_avg", batt_avg, 0);
    check("mrst_low", batt_low, 0);
    check("mrst_crit", batt_crit, 0);
    check("mrst_fault", a2d_fault, 0);
    check("mrst_busy", busy, 0);
    check("mrst_no_ack", n_ack, a0);
    check("mrst_one_strt", n_strt, s0 + 1);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
